// File: rtl/tt_io_exerciser.sv
// Host-driven I/O exerciser for a Tiny-Tapeout style user design.
// The exerciser drives the user inputs and pulses the user clock a counted
// number of times. It also samples the user outputs on request and returns
// them to the host through a valid/ready response channel.
module tt_io_exerciser #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [7:0]  ui_in,
  input  logic [7:0]  uo_out,
  output logic [7:0]  uio_in,
  input  logic [7:0]  uio_out,
  input  logic [7:0]  uio_oe,
  output logic        ena,
  output logic        um_clk,
  output logic        um_rst_n
);

  localparam int NUM_LANES = 8;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_CLOCK = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_CTRL  = 2'd3;

  typedef enum logic [1:0] {IDLE, CLK_HI, CLK_LO, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         ui_in_q, ui_in_d;
  logic [7:0]         drv_q, drv_d;
  logic               ena_q, ena_d;
  logic               um_rst_n_q, um_rst_n_d;
  logic               um_clk_q, um_clk_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic [7:0]         uio_val;
  logic               cmd_acc;

  // Pad loopback per bidir lane: the user design wins where it enables its driver.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign uio_val[g] = uio_oe[g] ? uio_out[g] : drv_q[g];
  end

  assign uio_in    = uio_val;
  assign cmd_ready = (state_q == IDLE);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign ui_in     = ui_in_q;
  assign ena       = ena_q;
  assign um_rst_n  = um_rst_n_q;
  assign um_clk    = um_clk_q;

  // Next-state: command decode, clock-pulse sequencing and response handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ui_in_d    = ui_in_q;
    drv_d      = drv_q;
    ena_d      = ena_q;
    um_rst_n_d = um_rst_n_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          unique case (cmd_op)
            OP_WRITE: begin
              ui_in_d = cmd_data[15:8];
              drv_d   = cmd_data[7:0];
            end
            OP_CLOCK: begin
              cnt_d = cmd_data[CNT_W-1:0];
              if (cmd_data[CNT_W-1:0] != '0) state_d = CLK_HI;
            end
            OP_READ: begin
              rsp_data_d = {uo_out, uio_val};
              state_d    = RESP;
            end
            OP_CTRL: begin
              ena_d      = cmd_data[0];
              um_rst_n_d = cmd_data[1];
            end
            default: ;
          endcase
        end
      end
      CLK_HI: state_d = CLK_LO;
      CLK_LO: begin
        // The count drops once per full pulse; the last low phase returns to idle.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
        else                    state_d = CLK_HI;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered so the user clock is glitch-free; it is gated by ena, but
    // pulses are still counted while it is held low.
    um_clk_d = (state_d == CLK_HI) && ena_q;
  end

  // State registers; reset aborts any pulse train or pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ui_in_q    <= '0;
      drv_q      <= '0;
      ena_q      <= 1'b0;
      um_rst_n_q <= 1'b0;
      um_clk_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ui_in_q    <= ui_in_d;
      drv_q      <= drv_d;
      ena_q      <= ena_d;
      um_rst_n_q <= um_rst_n_d;
      um_clk_q   <= um_clk_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
